// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// Owner encoding, response tag and default timing constants.
package mem_arb_pkg;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int DEF_RD_LATENCY   = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  function automatic tag_t tag_age(
    input tag_t   t,
    input logic   inv,
    input owner_e inv_owner
  );
    tag_t r;
    r = t;
    if (inv && t.owner == inv_owner) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Shift register of response tags, one stage per cycle of read latency.
// Entries of one owner can be invalidated as they advance.
module mem_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic   clk,
  input  logic   rst_n,
  input  tag_t   push,
  input  logic   inv,
  input  owner_e inv_owner,
  output tag_t   tail
);

  tag_t [RD_LATENCY-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage[i] <= tag_age(stage[i-1], inv, inv_owner);
      end
    end
  end

  assign tail = stage[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data onto one memory port and routes
// fixed-latency read data back to the issuing requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       if_win;
  logic       d_win;
  tag_t       push;
  tag_t       tail;

  assign starved = (starve_cnt == LIMIT);
  assign if_win  = if_req & ~flush & (~d_req | starved);
  assign d_win   = d_req & ~if_win;

  // Reset gates only the outputs; state is held by the async clear.
  assign if_gnt = if_win & rst_n;
  assign d_gnt  = d_win & rst_n;

  assign mem_req   = if_gnt | d_gnt;
  assign mem_addr  = d_gnt ? d_addr :
                     if_gnt ? if_addr : '0;
  assign mem_we    = d_gnt ? d_we : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_win) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    push       = '0;
    push.owner = OWN_FETCH;
    unique case (1'b1)
      if_win: begin
        push.valid = 1'b1;
        push.owner = OWN_FETCH;
      end
      d_win: begin
        push.valid = (d_we == 4'd0);
        push.owner = OWN_DATA;
      end
      default: ;
    endcase
  end

  mem_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .inv      (flush),
    .inv_owner(OWN_FETCH),
    .tail     (tail)
  );

  assign if_rvalid = tail.valid & (tail.owner == OWN_FETCH)
                   & ~flush;
  assign d_rvalid  = tail.valid & (tail.owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios
// followed by random traffic against a cycle-level reference.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int L  = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(
    .RD_LATENCY  (L),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starve_m = 0;
  int fq[$];
  int dq[$];
  bit use_fix = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    mem_rdata = use_fix ? 32'hDEADBEEF : $urandom;
  end

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               name, cyc, act, exp);
    end
  endtask

  // Reference: request side (grants, bus mux, expected responses)
  always @(negedge clk) begin
    bit fa, e_if, e_d;
    if (!rst_n) begin
      chk("reset_out",
          {if_gnt, d_gnt, mem_req, mem_we, if_rvalid,
           d_rvalid, if_rdata, d_rdata},
          '0);
      fq.delete();
      dq.delete();
      starve_m = 0;
    end else begin
      fa   = if_req && !flush;
      e_if = fa && (!d_req || starve_m == SL);
      e_d  = d_req && !e_if;
      chk("grant", {if_gnt, d_gnt, mem_req},
          {e_if, e_d, e_if | e_d});
      if (e_d)
        chk("bus_data", {mem_addr, mem_we, mem_wdata},
            {d_addr, d_we, d_wdata});
      else if (e_if)
        chk("bus_fetch", {mem_addr, mem_we, mem_wdata},
            {if_addr, 4'd0, 32'd0});
      if (e_if) fq.push_back(cyc + L);
      if (e_d && d_we == 4'd0) dq.push_back(cyc + L);
      if (!if_req || e_if) starve_m = 0;
      else if (starve_m < SL) starve_m++;
    end
  end

  // Monitor: response side
  always @(negedge clk) begin
    bit ei, ed;
    if (rst_n) begin
      if (flush) fq.delete();
      ei = (fq.size() > 0) && (fq[0] == cyc);
      ed = (dq.size() > 0) && (dq[0] == cyc);
      if (ei) void'(fq.pop_front());
      if (ed) void'(dq.pop_front());
      chk("if_rvalid", if_rvalid, ei);
      chk("if_rdata", if_rdata, ei ? mem_rdata : 32'd0);
      chk("d_rvalid", d_rvalid, ed);
      chk("d_rdata", d_rdata, ed ? mem_rdata : 32'd0);
    end
  end

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da,
                      input logic [3:0] we,
                      input logic [31:0] wd,
                      input logic fl);
    @(posedge clk);
    #1;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_addr  = da;
    d_we    = we;
    d_wdata = wd;
    flush   = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // lone fetch with fixed memory data
    use_fix = 1'b1;
    step(1, 32'h100, 0, 0, 0, 0, 0);
    idle(3);
    use_fix = 1'b0;

    // contention: fetch wins every fifth cycle
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h40 + k, 1, 32'h800 + k, 0, 0, 0);
      @(negedge clk);
      chk("contention", {if_gnt, d_gnt},
          (k == 4 || k == 9) ? 2'b10 : 2'b01);
    end
    idle(3);

    // store: no response expected
    step(0, 0, 1, 32'h203, 4'b1000, 32'hAB000000, 0);
    @(negedge clk);
    chk("store_bus", {mem_we, mem_addr}, {4'b1000, 32'h203});
    idle(3);

    // flush squashes both in-flight fetches
    step(1, 32'h10, 0, 0, 0, 0, 0);
    step(1, 32'h14, 0, 0, 0, 0, 0);
    step(1, 32'h18, 1, 32'h300, 0, 0, 1);
    idle(4);

    // interleave load / fetch / load
    step(0, 0, 1, 32'h400, 0, 0, 0);
    step(1, 32'h20, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h404, 0, 0, 0);
    idle(4);

    // reset mid-flight
    step(0, 0, 1, 32'h500, 0, 0, 0);
    @(posedge clk);
    #1;
    d_addr = 32'h504;
    rst_n  = 1'b0;
    idle(2);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    rst_n = 1'b1;
    idle(4);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] we;
      we = ($urandom_range(1) == 1) ? 4'($urandom) : 4'd0;
      step($urandom_range(3) != 0, $urandom,
           $urandom_range(2) != 0, $urandom,
           we, $urandom,
           $urandom_range(15) == 0);
    end
    idle(L + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
